// File: rtl/idu_decode_stage.sv
// idu_decode_stage: registered RV32I/RV64I decode between IFU and EXU.
// Define IDU_SKID_EN for a two-entry skid buffer with a registered in_ready.
module idu_decode_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_inst,
    output logic [2:0]      out_itype,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic            out_illegal
);

    localparam logic [2:0] TypeNull = 3'd0;
    localparam logic [2:0] TypeR    = 3'd1;
    localparam logic [2:0] TypeI    = 3'd2;
    localparam logic [2:0] TypeS    = 3'd3;
    localparam logic [2:0] TypeB    = 3'd4;
    localparam logic [2:0] TypeU    = 3'd5;
    localparam logic [2:0] TypeJ    = 3'd6;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic [2:0]      itype;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } entry_t;

    entry_t             dec;
    logic signed [31:0] imm32;

    // Every recognised opcode ends in 2'b11, so compressed encodings fall into default.
    always_comb begin
        dec         = '0;
        imm32       = '0;
        dec.pc      = in_pc;
        dec.inst    = in_inst;
        dec.itype   = TypeNull;
        dec.illegal = 1'b0;
        case (in_inst[6:0])
            7'b0110011: dec.itype = TypeR;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
                dec.itype = TypeI;
                imm32     = {{20{in_inst[31]}}, in_inst[31:20]};
            end
            7'b0100011: begin
                dec.itype = TypeS;
                imm32     = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            end
            7'b1100011: begin
                dec.itype = TypeB;
                imm32     = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                             in_inst[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec.itype = TypeU;
                imm32     = {in_inst[31:12], 12'b0};
            end
            7'b1101111: begin
                dec.itype = TypeJ;
                imm32     = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                             in_inst[30:21], 1'b0};
            end
            default: dec.illegal = 1'b1;
        endcase
        dec.imm = XLEN'(imm32);
    end

    entry_t main_q, main_d;
    logic   main_valid_q, main_valid_d;
    logic   accept;

`ifdef IDU_SKID_EN
    entry_t skid_q, skid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   in_ready_q, in_ready_d;
    logic   out_hs;

    assign in_ready = in_ready_q;
    assign accept   = in_valid && in_ready_q;
    assign out_hs   = main_valid_q && out_ready;

    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || out_hs) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = accept;
                if (accept) main_d = dec;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q       <= '0;
            main_valid_q <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            main_q       <= main_d;
            main_valid_q <= main_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end
`else
    assign in_ready = !main_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
        end else if (in_ready) begin
            main_valid_d = in_valid;
            if (accept) main_d = dec;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q       <= '0;
            main_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            main_valid_q <= main_valid_d;
        end
    end
`endif

    assign out_valid   = main_valid_q;
    assign out_pc      = main_q.pc;
    assign out_inst    = main_q.inst;
    assign out_itype   = main_q.itype;
    assign out_imm     = main_q.imm;
    assign out_illegal = main_q.illegal;
    assign out_rd      = main_q.inst[11:7];
    assign out_rs1     = main_q.inst[19:15];
    assign out_rs2     = main_q.inst[24:20];

endmodule

// File: tb/tb_idu_decode_stage.sv
// Scoreboard bench for idu_decode_stage: random traffic plus directed decode, stall,
// flush and reset cases, checked against a behavioural RV decode model.
module tb_idu_decode_stage;

    localparam int unsigned XLEN = 32;

    logic            clk;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_inst;
    logic [2:0]      out_itype;
    logic [XLEN-1:0] out_imm;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic            out_illegal;

    idu_decode_stage #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_inst    (in_inst),
        .in_pc      (in_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_inst   (out_inst),
        .out_itype  (out_itype),
        .out_imm    (out_imm),
        .out_rd     (out_rd),
        .out_rs1    (out_rs1),
        .out_rs2    (out_rs2),
        .out_illegal(out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic [2:0]      itype;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference decode: immediates assembled arithmetically from a sign-extended word.
    function automatic exp_t model(input logic [31:0] inst, input logic [XLEN-1:0] pc);
        exp_t   e;
        longint s;
        longint imm;
        int     t;
        s         = longint'($signed(inst));
        imm       = 0;
        t         = 0;
        e.pc      = pc;
        e.inst    = inst;
        e.illegal = 1'b0;
        if (inst[1:0] != 2'b11) begin
            e.illegal = 1'b1;
        end else begin
            case (inst[6:0])
                7'h33: t = 1;
                7'h13, 7'h03, 7'h67, 7'h73: begin t = 2; imm = s >>> 20; end
                7'h23: begin
                    t   = 3;
                    imm = ((s >>> 25) << 5) | longint'(inst[11:7]);
                end
                7'h63: begin
                    t   = 4;
                    imm = ((s >>> 31) << 12) | (longint'(inst[7]) << 11)
                        | (longint'(inst[30:25]) << 5) | (longint'(inst[11:8]) << 1);
                end
                7'h37, 7'h17: begin t = 5; imm = s & 64'hFFFF_FFFF_FFFF_F000; end
                7'h6F: begin
                    t   = 6;
                    imm = ((s >>> 31) << 20) | (longint'(inst[19:12]) << 12)
                        | (longint'(inst[20]) << 11) | (longint'(inst[30:21]) << 1);
                end
                default: e.illegal = 1'b1;
            endcase
        end
        e.itype = 3'(t);
        e.imm   = imm[XLEN-1:0];
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        logic [6:0]  ops [10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37,
                                  7'h17, 7'h6F};
        r = $urandom;
        if ($urandom_range(0, 9) == 0) return r;
        return {r[31:7], ops[$urandom_range(0, 9)]};
    endfunction

    // Monitor: compare the presented entry to the queue head, then apply this edge's events.
    always @(negedge clk) begin
        bit   exp_valid;
        bit   exp_ready;
        exp_t h;
        if (!rst) begin
            exp_valid = sb.size() != 0;
`ifdef IDU_SKID_EN
            exp_ready = sb.size() < 2;
`else
            exp_ready = !exp_valid || out_ready;
`endif
            chk("out_valid", 64'(out_valid), 64'(exp_valid));
            chk("in_ready", 64'(in_ready), 64'(exp_ready));
            if (exp_valid) begin
                h = sb[0];
                chk("out_pc", 64'(out_pc), 64'(h.pc));
                chk("out_inst", 64'(out_inst), 64'(h.inst));
                chk("out_itype", 64'(out_itype), 64'(h.itype));
                chk("out_imm", 64'(out_imm), 64'(h.imm));
                chk("out_rd", 64'(out_rd), 64'(h.inst[11:7]));
                chk("out_rs1", 64'(out_rs1), 64'(h.inst[19:15]));
                chk("out_rs2", 64'(out_rs2), 64'(h.inst[24:20]));
                chk("out_illegal", 64'(out_illegal), 64'(h.illegal));
            end
            if (flush) begin
                sb.delete();
            end else begin
                if (exp_valid && out_ready) void'(sb.pop_front());
                if (in_valid && exp_ready) sb.push_back(model(in_inst, in_pc));
            end
        end
    end

    task automatic reset_check(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_pc"}, 64'(out_pc), 64'd0);
        chk({tag, "_out_inst"}, 64'(out_inst), 64'd0);
        chk({tag, "_out_itype"}, 64'(out_itype), 64'd0);
        chk({tag, "_out_imm"}, 64'(out_imm), 64'd0);
        chk({tag, "_out_rd"}, 64'(out_rd), 64'd0);
        chk({tag, "_out_rs1"}, 64'(out_rs1), 64'd0);
        chk({tag, "_out_rs2"}, 64'(out_rs2), 64'd0);
        chk({tag, "_out_illegal"}, 64'(out_illegal), 64'd0);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    endtask

    logic [31:0] d_inst [6] = '{32'h00500093, 32'hFE000EE3, 32'h123452B7, 32'h008000EF,
                                32'h00000000, 32'hFFFFFFFF};
    logic [2:0]  d_type [6] = '{3'd2, 3'd4, 3'd5, 3'd6, 3'd0, 3'd0};
    logic [63:0] d_imm  [6] = '{64'd5, 64'hFFFF_FFFF_FFFF_FFFC, 64'h12345000, 64'd8, 64'd0,
                                64'd0};
    logic [4:0]  d_rd   [6] = '{5'd1, 5'd29, 5'd5, 5'd1, 5'd0, 5'd31};
    logic        d_ill  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        logic [63:0]     want_imm;
        logic [31:0]     bp [4];
        int              idx;
        int              acc_stalled;
        bit              rdy;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_inst   = '0;
        in_pc     = '0;
        out_ready = 1'b0;
        #3;
        reset_check("rst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed back-to-back decode with out_ready held high.
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_inst  = d_inst[k];
            in_pc    = XLEN'(64'h8000_0000 + 64'(4 * k));
            @(posedge clk);
            #1;
            want_imm = d_imm[k];
            chk("dir_valid", 64'(out_valid), 64'd1);
            chk("dir_itype", 64'(out_itype), 64'(d_type[k]));
            chk("dir_imm", 64'(out_imm), 64'(want_imm[XLEN-1:0]));
            chk("dir_rd", 64'(out_rd), 64'(d_rd[k]));
            chk("dir_illegal", 64'(out_illegal), 64'(d_ill[k]));
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Backpressure: stall three cycles while offering four instructions.
        for (int k = 0; k < 4; k++) bp[k] = rand_inst();
        idx       = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 13 && idx < 4; c++) begin
            if (c == 3) begin
                acc_stalled = idx;
                out_ready   = 1'b1;
            end
            in_valid = 1'b1;
            in_inst  = bp[idx];
            in_pc    = XLEN'(64'h1000 + 64'(4 * idx));
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) idx++;
        end
        in_valid = 1'b0;
`ifdef IDU_SKID_EN
        chk("bp_accepted_stalled", 64'(acc_stalled), 64'd2);
`else
        chk("bp_accepted_stalled", 64'(acc_stalled), 64'd1);
`endif
        chk("bp_all_accepted", 64'(idx), 64'd4);
        repeat (4) @(posedge clk);
        #1;

        // Flush with a buffered entry and a simultaneous input offer.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = 32'h00100113;
        in_pc     = XLEN'(64'h2000);
        @(posedge clk);
        #1;
        in_inst = 32'h00200193;
        in_pc   = XLEN'(64'h2004);
        flush   = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset pulsed mid-stall clears outputs asynchronously.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = 32'h00300213;
        in_pc     = XLEN'(64'h3000);
        @(posedge clk);
        #1;
        in_inst = 32'hFE000EE3;
        in_pc   = XLEN'(64'h3004);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        reset_check("midrst");
        sb.delete();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Random traffic with occasional flushes.
        for (int c = 0; c < 600; c++) begin
            in_valid  = $urandom_range(0, 9) < 7;
            in_inst   = rand_inst();
            in_pc     = XLEN'({$urandom(), $urandom()});
            out_ready = $urandom_range(0, 9) < 6;
            flush     = $urandom_range(0, 24) == 0;
            @(posedge clk);
            #1;
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/idu_decode_stage.md
# idu_decode_stage

Registered instruction-decode stage between IFU and EXU in the NPC core. It accepts one fetched instruction per cycle over a valid/ready handshake. It classifies the opcode into an instruction type, extracts register indices, and builds the sign-extended immediate for every RV32I/RV64I format. The result is presented one cycle later through a valid/ready output with flush support. It supersedes the purely combinational type lookup: it adds B-type, SYSTEM, an illegal flag, a XLEN parameter, and pipeline buffering.

## Interface
- XLEN, 32, datapath width of pc/imm; legal values 32 or 64.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  kill all buffered entries (redirect from EXU).
- in_valid  in  1  upstream offers an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_inst  in  32  raw instruction.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  decoded entry available.
- out_ready  in  1  downstream accepts this cycle.
- out_pc  out  XLEN  pc of the entry.
- out_inst  out  32  raw instruction of the entry.
- out_itype  out  3  type: NULL=0, R=1, I=2, S=3, B=4, U=5, J=6.
- out_imm  out  XLEN  sign-extended immediate.
- out_rd / out_rs1 / out_rs2  out  5 each  inst[11:7] / inst[19:15] / inst[24:20].
- out_illegal  out  1  opcode unrecognised or inst[1:0]!=2'b11.

## Operation
**Opcode map** (inst[6:0]):
- 0110011 → R.
- 0010011, 0000011, 1100111, 1110011 → I.
- 0100011 → S.
- 1100011 → B.
- 0110111, 0010111 → U.
- 1101111 → J.
- Anything else → NULL with illegal=1.
- Any opcode with inst[1:0]!=11 → NULL with illegal=1.

**Immediates**, all sign-extended from inst[31] to XLEN:
- I: inst[31:20].
- S: {inst[31:25],inst[11:7]}.
- B: {inst[31],inst[7],inst[30:25],inst[11:8],1'b0}.
- U: {inst[31:12],12'b0}.
- J: {inst[31],inst[19:12],inst[20],inst[30:21],1'b0}.
- R/NULL: 0.

**Pipeline and handshake**
- Decode is combinational on in_inst and captured at handshake (in_valid && in_ready).
- The output register holds all decoded fields and the raw inst. Fields are stable while out_valid && !out_ready.
- Output handshake occurs when out_valid && out_ready. Entries leave strictly in acceptance order; no entry is duplicated or dropped except by flush.

**Flush**
- On a flush edge all entries are invalidated.
- An input handshake in the same cycle as flush is discarded.
- flush has priority over every other event.

## Timing
- Latency: 1 cycle from input handshake to out_valid. Throughput: 1 instruction/cycle when out_ready=1.
- While rst is high: out_valid=0, and out_pc, out_inst, out_itype, out_imm, out_rd, out_rs1, out_rs2, out_illegal are all 0. in_ready is per mode below.
- Reset asserted mid-transfer drops all entries immediately (asynchronously). No handshake completes while rst=1.
- The cycle after flush: out_valid=0 and in_ready=1.

## Configuration
**IDU_SKID_EN defined: two-entry skid buffer (main + skid).**
- in_ready is a pure register, equal to "skid empty"; reset value 1.
- Accept while main is full and the output is stalled → the entry goes to skid, and in_ready=0 from the next cycle.
- On output handshake: skid moves to main, and in_ready returns to 1 the next cycle.
- There is no combinational path from out_ready to in_ready.

**IDU_SKID_EN undefined: single register.**
- in_ready = !out_valid || out_ready (combinational). It reads 1 during reset.
- Simultaneous output and input handshakes replace the entry in the same edge.

Both modes give identical ordering and data; they differ only in in_ready timing.

## Test plan
- Reset, then in_inst=0x00500093 pc=0x80000000 → next cycle out_valid=1, itype=2, imm=5, rd=1, rs1=0, illegal=0.
- in_inst=0xFE000EE3 → itype=4, imm=0xFFFFFFFC (XLEN=32) / 0xFFFFFFFFFFFFFFFC (XLEN=64).
- Back-to-back 0x123452B7, 0x008000EF with out_ready=1 → consecutive cycles: itype=5 imm=0x12345000 rd=5, then itype=6 imm=8 rd=1.
- in_inst=0x00000000 and 0xFFFFFFFF → itype=0, illegal=1, imm=0.
- Backpressure: out_ready=0 for 3 cycles while streaming 4 instructions.
  - Expected: outputs stable; SKID mode accepts exactly 2 then in_ready=0, single mode accepts 1.
  - After out_ready=1: all accepted entries emerge in order.
- flush asserted with a buffered entry and a simultaneous in_valid → next cycle out_valid=0 and the flushed/discarded instructions never appear. Repeat with rst pulsed mid-stall → all outputs 0 immediately.
